phase_two: RTL and testbench

Phase-two integration slice of the 16-bit accumulator processor datapath. It holds the instruction register and its field decode, the immediate extender, the eight-entry named register file and the unified word memory. Control signals arrive from the control unit. ALU results and the PC arrive from the phase-one slice.

---
 rtl/phase_two_pkg.sv | 28 ++
 rtl/phase_two_mem.sv | 39 +++
 rtl/phase_two_regfile.sv | 47 ++++
 rtl/phase_two.sv | 98 +++++++++
 tb/tb_phase_two.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/phase_two_pkg.sv
// rtl/phase_two_pkg.sv - shared constants and helpers for the phase-two datapath slice
package phase_two_pkg;

  localparam int          ADDR_W_DEF   = 13;
  localparam logic [15:0] SP_RESET_DEF = 16'h1FFF;

  localparam logic [2:0] WR = 3'd0;
  localparam logic [2:0] MA = 3'd1;
  localparam logic [2:0] AR = 3'd2;
  localparam logic [2:0] NA = 3'd3;
  localparam logic [2:0] RV = 3'd4;
  localparam logic [2:0] SP = 3'd5;
  localparam logic [2:0] RA = 3'd6;
  localparam logic [2:0] TP = 3'd7;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int IMM_MSB  = 11;
  localparam int LOC_BIT  = 4;
  localparam int RS_MSB   = 7;
  localparam int RS_LSB   = 5;
  localparam int RS2_MSB  = 2;

  function automatic logic [15:0] ext_imm(input logic [11:0] imm, input logic zero_ext);
    return zero_ext ? {4'b0000, imm} : {{4{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/phase_two_mem.sv
// rtl/phase_two_mem.sv - single-port read-first word RAM with preloaded contents
module phase_two_mem
  import phase_two_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0] mem [0:DEPTH-1] = '{
    0: 16'h0000,  1: 16'hAAAA,  2: 16'h0001,  3: 16'hBBBB,
    4: 16'h0002,  5: 16'hCCCC,  6: 16'h0003,  7: 16'hDDDD,
    8: 16'h0004,  9: 16'hEEEE, 10: 16'h0005, 11: 16'h1111,
    12: 16'h0006, 13: 16'h2222, default: 16'h0000
  };

  // Contents survive reset; only a write racing an asserted reset is dropped.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= 16'h0000;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/phase_two_regfile.sv
// rtl/phase_two_regfile.sv - eight named 16-bit registers, one write port, one select read port
module phase_two_regfile
  import phase_two_pkg::*;
#(
  parameter logic [15:0] SP_RESET = SP_RESET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  wr_sel,
  input  logic [15:0] wr_data,
  input  logic [2:0]  rd_sel,
  output logic [15:0] rd_data,
  output logic [15:0] wr,
  output logic [15:0] ma,
  output logic [15:0] ar,
  output logic [15:0] na,
  output logic [15:0] rv,
  output logic [15:0] sp,
  output logic [15:0] ra,
  output logic [15:0] tp
);

  logic [15:0] regs [0:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= (3'(i) == SP) ? SP_RESET : 16'h0000;
      end
    end else if (we) begin
      regs[wr_sel] <= wr_data;
    end
  end

  assign rd_data = regs[rd_sel];

  assign wr = regs[WR];
  assign ma = regs[MA];
  assign ar = regs[AR];
  assign na = regs[NA];
  assign rv = regs[RV];
  assign sp = regs[SP];
  assign ra = regs[RA];
  assign tp = regs[TP];

endmodule

// File: rtl/phase_two.sv
// rtl/phase_two.sv - IR decode, immediate extend, register file and word memory integration
module phase_two
  import phase_two_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter logic [15:0] SP_RESET = SP_RESET_DEF
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        IRWrite,
  input  logic [15:0] IRInput,
  input  logic        EXT,
  input  logic        RegWrite,
  input  logic [2:0]  RegDest,
  input  logic        Call,
  input  logic [15:0] fromPC,
  input  logic        PopPush,
  input  logic [15:0] ALUoutput,
  input  logic        MemWrite,
  output logic [15:0] Imm_Out,
  output logic [15:0] Mem_Out,
  output logic [15:0] wr,
  output logic [15:0] ma,
  output logic [15:0] ar,
  output logic [15:0] na,
  output logic [15:0] rv,
  output logic [15:0] sp,
  output logic [15:0] ra,
  output logic [15:0] tp,
  output logic [3:0]  Opcode,
  output logic        LocationSelect,
  output logic [2:0]  RegSelect,
  output logic [2:0]  RegSelect2,
  output logic [3:0]  IR41Delta,
  output logic [3:0]  funct
);

  logic [15:0]       ir;
  logic [15:0]       reg_wdata;
  logic [15:0]       sel_data;
  logic [15:0]       addr_full;
  logic [ADDR_W-1:0] mem_addr;
  logic              addr_unused;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ir <= 16'h0000;
    end else if (IRWrite) begin
      ir <= IRInput;
    end
  end

  assign Opcode         = ir[OPC_MSB:OPC_LSB];
  assign LocationSelect = ir[LOC_BIT];
  assign RegSelect      = ir[RS_MSB:RS_LSB];
  assign RegSelect2     = ir[RS2_MSB:0];
  assign IR41Delta      = ir[LOC_BIT:1];
  assign funct          = ir[3:0];
  assign Imm_Out        = ext_imm(ir[IMM_MSB:0], EXT);

  // Loads capture the previous cycle's read, so the address must settle a cycle early.
  assign reg_wdata   = Call ? fromPC : Mem_Out;
  assign addr_full   = PopPush ? ALUoutput : ma;
  assign mem_addr    = addr_full[ADDR_W-1:0];
  assign addr_unused = ^addr_full[15:ADDR_W];

  phase_two_regfile #(
    .SP_RESET (SP_RESET)
  ) u_regfile (
    .clk     (CLK),
    .rst     (Reset),
    .we      (RegWrite),
    .wr_sel  (RegDest),
    .wr_data (reg_wdata),
    .rd_sel  (RegSelect),
    .rd_data (sel_data),
    .wr      (wr),
    .ma      (ma),
    .ar      (ar),
    .na      (na),
    .rv      (rv),
    .sp      (sp),
    .ra      (ra),
    .tp      (tp)
  );

  phase_two_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (CLK),
    .rst   (Reset),
    .addr  (mem_addr),
    .we    (MemWrite),
    .wdata (sel_data),
    .rdata (Mem_Out)
  );

endmodule

// File: tb/tb_phase_two.sv
// tb/tb_phase_two.sv - directed self-checking bench for phase_two
module tb_phase_two;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        IRWrite;
  logic [15:0] IRInput;
  logic        EXT;
  logic        RegWrite;
  logic [2:0]  RegDest;
  logic        Call;
  logic [15:0] fromPC;
  logic        PopPush;
  logic [15:0] ALUoutput;
  logic        MemWrite;
  logic [15:0] Imm_Out, Mem_Out;
  logic [15:0] wr, ma, ar, na, rv, sp, ra, tp;
  logic [3:0]  Opcode;
  logic        LocationSelect;
  logic [2:0]  RegSelect, RegSelect2;
  logic [3:0]  IR41Delta, funct;

  int total = 0;
  int bad   = 0;

  phase_two dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .IRWrite        (IRWrite),
    .IRInput        (IRInput),
    .EXT            (EXT),
    .RegWrite       (RegWrite),
    .RegDest        (RegDest),
    .Call           (Call),
    .fromPC         (fromPC),
    .PopPush        (PopPush),
    .ALUoutput      (ALUoutput),
    .MemWrite       (MemWrite),
    .Imm_Out        (Imm_Out),
    .Mem_Out        (Mem_Out),
    .wr             (wr),
    .ma             (ma),
    .ar             (ar),
    .na             (na),
    .rv             (rv),
    .sp             (sp),
    .ra             (ra),
    .tp             (tp),
    .Opcode         (Opcode),
    .LocationSelect (LocationSelect),
    .RegSelect      (RegSelect),
    .RegSelect2     (RegSelect2),
    .IR41Delta      (IR41Delta),
    .funct          (funct)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1; IRWrite = 1'b0; IRInput = 16'h0000; EXT = 1'b0;
    RegWrite = 1'b0; RegDest = 3'd0; Call = 1'b0; fromPC = 16'h0000;
    PopPush = 1'b0; ALUoutput = 16'h0000; MemWrite = 1'b0;
    step(); step();
    check("rst_wr", wr, 16'h0000);
    check("rst_sp", sp, 16'h1FFF);
    check("rst_mem_out", Mem_Out, 16'h0000);
    check("rst_opcode", {12'h0, Opcode}, 16'h0000);
    Reset = 1'b0;
    step();

    IRWrite = 1'b1; IRInput = 16'h0F00;
    step();
    IRWrite = 1'b0;
    check("ir0f00_loc", {15'h0, LocationSelect}, 16'h0000);
    check("ir0f00_rs", {13'h0, RegSelect}, 16'h0000);
    check("ir0f00_rs2", {13'h0, RegSelect2}, 16'h0000);
    check("ir0f00_opc", {12'h0, Opcode}, 16'h0000);
    EXT = 1'b0; #1;
    check("imm_sext", Imm_Out, 16'hFF00);
    EXT = 1'b1; #1;
    check("imm_zext", Imm_Out, 16'h0F00);

    RegWrite = 1'b1; RegDest = 3'd1; Call = 1'b1; fromPC = 16'h0003;
    step();
    RegWrite = 1'b0;
    check("ma_link", ma, 16'h0003);
    step();
    check("read_ma3", Mem_Out, 16'hBBBB);

    PopPush = 1'b1; ALUoutput = 16'h0000; RegWrite = 1'b1; RegDest = 3'd1; Call = 1'b0;
    step();
    RegWrite = 1'b0;
    check("ma_load", ma, 16'hBBBB);
    check("read_alu0", Mem_Out, 16'h0000);

    IRWrite = 1'b1; IRInput = 16'h0F20;
    step();
    IRWrite = 1'b0;
    check("ir0f20_rs", {13'h0, RegSelect}, 16'h0001);
    check("ir0f20_delta", {12'h0, IR41Delta}, 16'h0000);

    PopPush = 1'b1; ALUoutput = 16'h0007; MemWrite = 1'b1;
    step();
    MemWrite = 1'b0;
    check("read_first", Mem_Out, 16'hDDDD);
    step();
    check("mem7_written", Mem_Out, 16'hBBBB);

    ALUoutput = 16'hE00B;
    step();
    check("addr_trunc", Mem_Out, 16'h1111);

    IRWrite = 1'b1; IRInput = 16'hA8B5;
    step();
    IRWrite = 1'b0;
    check("irA8B5_opc", {12'h0, Opcode}, 16'h000A);
    check("irA8B5_loc", {15'h0, LocationSelect}, 16'h0001);
    check("irA8B5_rs", {13'h0, RegSelect}, 16'h0005);
    check("irA8B5_rs2", {13'h0, RegSelect2}, 16'h0005);
    check("irA8B5_delta", {12'h0, IR41Delta}, 16'h000A);
    check("irA8B5_funct", {12'h0, funct}, 16'h0005);
    EXT = 1'b0; #1;
    check("irA8B5_sext", Imm_Out, 16'hF8B5);
    EXT = 1'b1; #1;
    check("irA8B5_zext", Imm_Out, 16'h08B5);

    // RegSelect=5 (sp): memory gets pre-edge sp at pre-edge ma (0x1BBB) while sp is rewritten.
    PopPush = 1'b0; MemWrite = 1'b1; RegWrite = 1'b1; RegDest = 3'd5; Call = 1'b1; fromPC = 16'h0042;
    step();
    MemWrite = 1'b0; RegWrite = 1'b0;
    check("simul_sp", sp, 16'h0042);
    check("simul_read_old", Mem_Out, 16'h0000);
    step();
    check("simul_mem_data", Mem_Out, 16'h1FFF);

    RegWrite = 1'b1; RegDest = 3'd7; Call = 1'b1; fromPC = 16'h1234;
    step();
    RegWrite = 1'b0;
    check("tp_write", tp, 16'h1234);
    check("ra_untouched", ra, 16'h0000);

    RegWrite = 1'b1; RegDest = 3'd0; Call = 1'b1; fromPC = 16'h5555;
    #2 Reset = 1'b1;
    #1;
    check("async_rst_wr", wr, 16'h0000);
    check("async_rst_sp", sp, 16'h1FFF);
    check("async_rst_ma", ma, 16'h0000);
    check("async_rst_tp", tp, 16'h0000);
    check("async_rst_mem_out", Mem_Out, 16'h0000);
    step();
    check("rst_held_wr", wr, 16'h0000);
    RegWrite = 1'b0;
    Reset = 1'b0;
    PopPush = 1'b1; ALUoutput = 16'h0007;
    step();
    check("mem_kept", Mem_Out, 16'hBBBB);
    check("ir_reset", {12'h0, Opcode}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
